// File: rtl/rtc_campos_pkg.sv
// Shared field codes, per-field BCD limits, RTC register map and BCD step helpers
// for the date/time/timer field editor.
package rtc_campos_pkg;

    localparam logic [3:0] F_NONE    = 4'd0;
    localparam logic [3:0] F_CLK_SEG = 4'd1;
    localparam logic [3:0] F_CLK_MIN = 4'd2;
    localparam logic [3:0] F_CLK_HOR = 4'd3;
    localparam logic [3:0] F_DIA     = 4'd4;
    localparam logic [3:0] F_MES     = 4'd5;
    localparam logic [3:0] F_YEAR    = 4'd6;
    localparam logic [3:0] F_TMR_SEG = 4'd7;
    localparam logic [3:0] F_TMR_MIN = 4'd8;
    localparam logic [3:0] F_TMR_HOR = 4'd9;

    // Indexed by field code; entry 0 is the "no field" slot.
    localparam logic [9:0][7:0] CAMPO_MIN  = {8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                                              8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    localparam logic [9:0][7:0] CAMPO_MAX  = {8'h23, 8'h59, 8'h59, 8'h99, 8'h12,
                                              8'h31, 8'h23, 8'h59, 8'h59, 8'h00};
    localparam logic [9:0][7:0] CAMPO_ADDR = {8'h43, 8'h42, 8'h41, 8'h26, 8'h25,
                                              8'h24, 8'h23, 8'h22, 8'h21, 8'h00};

    typedef enum logic {ST_IDLE, ST_REQ} commit_st_t;

    function automatic logic bcd_fuera(input logic [7:0] v, input logic [7:0] mn,
                                       input logic [7:0] mx);
        return (v[7:4] > 4'd9) || (v[3:0] > 4'd9) || (v < mn) || (v > mx);
    endfunction

    // Garbage loaded from the RTC snaps to the nearest wrap point.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] mn,
                                           input logic [7:0] mx);
        if (bcd_fuera(v, mn, mx) || v == mx) return mn;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return v + 8'd1;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] mn,
                                           input logic [7:0] mx);
        if (bcd_fuera(v, mn, mx) || v == mn) return mx;
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return v - 8'd1;
    endfunction

endpackage

// File: rtl/repetidor_tecla.sv
// Key auto-repeat: one step the cycle after a press, then after REP_DELAY held
// cycles, then every REP_PERIOD held cycles.
module repetidor_tecla #(
    parameter int REP_DELAY  = 25_000_000,
    parameter int REP_PERIOD = 5_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_key,
    output logic o_step
);
    localparam int CW = $clog2((REP_DELAY > REP_PERIOD ? REP_DELAY : REP_PERIOD) + 1);

    logic          r_key_d;
    logic          r_rep;
    logic          r_step;
    logic [CW-1:0] r_cnt;

    // r_key_d keeps tracking during clear so a key held across a clear never fakes a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_key_d <= 1'b0;
            r_rep   <= 1'b0;
            r_step  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_key_d <= i_key;
            r_step  <= 1'b0;
            if (i_clr || !i_key) begin
                r_cnt <= '0;
                r_rep <= 1'b0;
            end else if (!r_key_d) begin
                r_step <= 1'b1;
                r_cnt  <= '0;
                r_rep  <= 1'b0;
            end else if (r_cnt == CW'(r_rep ? REP_PERIOD - 1 : REP_DELAY - 1)) begin
                r_step <= 1'b1;
                r_cnt  <= '0;
                r_rep  <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_step = r_step;

endmodule

// File: rtl/editor_campos.sv
// Nine BCD clock/date/timer fields edited with up/down keys; dirty fields are
// written back to the RTC one at a time through a req/ack handshake.
module editor_campos
    import rtc_campos_pkg::*;
#(
    parameter int REP_DELAY  = 25_000_000,
    parameter int REP_PERIOD = 5_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       edit_en,
    input  logic [3:0] puntero,
    input  logic       arriba,
    input  logic       abajo,
    input  logic       ld_en,
    input  logic [3:0] ld_idx,
    input  logic [7:0] ld_data,
    output logic [7:0] campo_val,
    output logic       wr_req,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic       wr_ack
);
    logic            w_sel_ok, w_both, w_clr;
    logic            w_up_step, w_dn_step, w_inc, w_dec;
    logic [9:1][7:0] r_campo;
    logic [9:1]      r_dirty;
    logic [3:0]      w_pick;
    logic [7:0]      w_pick_addr, w_pick_data;
    logic            w_latch;
    logic [7:0]      r_wr_addr, r_wr_data;
    commit_st_t      r_st, w_st_nx;

    assign w_sel_ok = edit_en && (puntero >= F_CLK_SEG) && (puntero <= F_TMR_HOR);
    assign w_both   = arriba && abajo;
    assign w_clr    = !w_sel_ok || w_both;

    repetidor_tecla #(.REP_DELAY(REP_DELAY), .REP_PERIOD(REP_PERIOD)) u_rep_arriba (
        .clk(clk), .reset(reset), .i_clr(w_clr), .i_key(arriba), .o_step(w_up_step));
    repetidor_tecla #(.REP_DELAY(REP_DELAY), .REP_PERIOD(REP_PERIOD)) u_rep_abajo (
        .clk(clk), .reset(reset), .i_clr(w_clr), .i_key(abajo), .o_step(w_dn_step));

    assign w_inc = w_up_step && !w_dn_step && w_sel_ok && !w_both;
    assign w_dec = w_dn_step && !w_up_step && w_sel_ok && !w_both;

    always_comb begin
        campo_val = 8'h00;
        for (int i = 1; i <= 9; i++)
            if (puntero == 4'(i)) campo_val = r_campo[i];
    end

    // A step needs puntero on the field, which also makes it ineligible, so the
    // dirty set and the commit clear never land on the same field together.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i <= 9; i++) r_campo[i] <= CAMPO_MIN[i];
            r_dirty <= '0;
        end else begin
            for (int i = 1; i <= 9; i++) begin
                if (puntero == 4'(i) && (w_inc || w_dec)) begin
                    r_campo[i] <= w_inc ? bcd_inc(r_campo[i], CAMPO_MIN[i], CAMPO_MAX[i])
                                        : bcd_dec(r_campo[i], CAMPO_MIN[i], CAMPO_MAX[i]);
                    r_dirty[i] <= 1'b1;
                end else begin
                    if (ld_en && ld_idx == 4'(i) && !r_dirty[i] && !(edit_en && puntero == 4'(i)))
                        r_campo[i] <= ld_data;
                    if (w_latch && w_pick == 4'(i))
                        r_dirty[i] <= 1'b0;
                end
            end
        end
    end

    // Descending scan so the lowest eligible code is the one left standing.
    always_comb begin
        w_pick      = 4'd0;
        w_pick_addr = 8'h00;
        w_pick_data = 8'h00;
        for (int i = 9; i >= 1; i--) begin
            if (r_dirty[i] && (!edit_en || puntero != 4'(i))) begin
                w_pick      = 4'(i);
                w_pick_addr = CAMPO_ADDR[i];
                w_pick_data = r_campo[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_st      <= ST_IDLE;
            r_wr_addr <= 8'h00;
            r_wr_data <= 8'h00;
        end else begin
            r_st <= w_st_nx;
            if (w_latch) begin
                r_wr_addr <= w_pick_addr;
                r_wr_data <= w_pick_data;
            end
        end
    end

    always_comb begin
        w_st_nx = r_st;
        w_latch = 1'b0;
        wr_req  = 1'b0;
        case (r_st)
            ST_IDLE: if (w_pick != F_NONE) begin
                w_latch = 1'b1;
                w_st_nx = ST_REQ;
            end
            ST_REQ: begin
                wr_req = 1'b1;
                if (wr_ack) w_st_nx = ST_IDLE;
            end
            default: w_st_nx = ST_IDLE;
        endcase
    end

    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

endmodule
